// File: rtl/abru_mem_pkg.sv
// Shared definitions for the image-RAM port arbiter: geometry, requester ids,
// arbiter state encoding and a one-hot helper.
package abru_mem_pkg;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef enum int {
        REQ_RX   = 0,
        REQ_PROC = 1,
        REQ_TX   = 2
    } req_id_e;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req=1, searching
// upward with wrap from last_owner+1.
module rr_pick
    import abru_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   pick,
    output logic               any_req
);

    logic [IDX_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        pick    = last_owner;
        any_req = |req;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, last_owner} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter sharing the single-port image RAM between the
// Rx writer, the processing core and the Tx retriever.
module mem_port_arbiter
    import abru_mem_pkg::*;
#(
    parameter int MAX_BURST = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        acc,
    input  logic [NUM_REQ-1:0]        wen,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_en,
    output logic                      ram_wen,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    input  logic [DATA_W-1:0]         ram_dout,
    output logic [0:0]                arb_state
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic [CNT_W-1:0] beat_cnt;
    logic             rd_pend;
    logic [IDX_W-1:0] rd_owner;

    logic own_req;
    logic own_acc;
    logic others_waiting;
    logic burst_full;

    rr_pick u_pick (
        .req        (req),
        .last_owner (last_owner),
        .pick       (pick),
        .any_req    (any_req)
    );

    // gnt is one-hot-or-zero, so masking with it selects the owner's lines.
    always_comb begin
        own_req        = |(req & gnt);
        own_acc        = |(acc & gnt);
        others_waiting = |(req & ~gnt);
        burst_full     = own_acc && (beat_cnt == CNT_W'(MAX_BURST - 1));
    end

    always_comb begin
        ram_en   = own_acc;
        ram_wen  = |(acc & wen & gnt);
        ram_addr = '0;
        ram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                ram_addr = addr[i*ADDR_W +: ADDR_W];
                ram_din  = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(REQ_TX);
            beat_cnt   <= '0;
            gnt        <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= '0;
        end else begin
            rd_pend  <= ram_en & ~ram_wen;
            rd_owner <= owner;
            if (state == ARB_IDLE) begin
                if (any_req) begin
                    state    <= ARB_BUSY;
                    owner    <= pick;
                    gnt      <= idx_onehot(pick);
                    beat_cnt <= '0;
                end
            end else begin
                // The beat that fills the burst is still honoured; release takes effect at this edge.
                if (!own_req || (burst_full && others_waiting)) begin
                    state      <= ARB_IDLE;
                    gnt        <= '0;
                    last_owner <= owner;
                    beat_cnt   <= '0;
                end else if (burst_full) begin
                    beat_cnt <= '0;
                end else if (own_acc) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rvalid    = rd_pend ? idx_onehot(rd_owner) : '0;
    assign rdata     = ram_dout;
    assign arb_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM, a read-return
// scoreboard and per-cycle invariant checks.
module tb_mem_port_arbiter;
    import abru_mem_pkg::*;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        acc;
    logic [NUM_REQ-1:0]        wen;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      ram_en;
    logic                      ram_wen;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_din;
    logic [DATA_W-1:0]         ram_dout;
    logic [0:0]                arb_state;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    bit mon_on  = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                own_q[$];
    logic [DATA_W-1:0] shadow[int];
    logic [DATA_W-1:0] mem[0:(1<<ADDR_W)-1];

    mem_port_arbiter #(.MAX_BURST(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .acc       (acc),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .arb_state (arb_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    end

    // behavioural single-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) mem[ram_addr] <= ram_din;
            else         ram_dout      <= mem[ram_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_acc(input int i, input logic w, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        acc[i] = 1'b1;
        wen[i] = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_acc();
        acc = '0;
        wen = '0;
    endtask

    function automatic logic [DATA_W-1:0] shadow_get(input int a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    // Owner beat: updates the shadow for writes, queues the expected return for reads.
    task automatic beat(input int i, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        drive_acc(i, w, a, d);
        if (w) begin
            shadow[int'(a)] = d;
        end else begin
            exp_q.push_back(shadow_get(int'(a)));
            own_q.push_back(i);
        end
    endtask

    // scoreboard and invariants
    always @(negedge clk) begin
        if (mon_on) begin
            n_total++;
            assert ($onehot0(gnt) && $onehot0(rvalid) && (!ram_en || gnt != '0)) n_pass++;
            else begin
                n_fail++;
                $error("FAIL invariant: observed gnt=%b rvalid=%b ram_en=%b, required one-hot-or-zero and no ram_en without gnt",
                       gnt, rvalid, ram_en);
            end
            if (rvalid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    logic [DATA_W-1:0] d;
                    int                o;
                    d = exp_q.pop_front();
                    o = own_q.pop_front();
                    chk("sb_rdata", 32'(rdata), 32'(d));
                    chk("sb_rvalid_owner", 32'(rvalid), 32'(1) << o);
                end
            end
        end
    end

    initial begin
        int order[4] = '{0, 1, 2, 0};
        int o;
        rst_n = 1'b0;
        req   = '0;
        acc   = '0;
        wen   = '0;
        addr  = '0;
        wdata = '0;

        // reset state
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        chk("rst_state", 32'(arb_state), 32'(ARB_IDLE));
        mon_on = 1;

        // 1: single requester write then read
        rst_n = 1'b1;
        req   = 3'b001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'b001);
        chk("t1_state", 32'(arb_state), 32'(ARB_BUSY));
        beat(0, 1'b1, 18'h00010, 8'hA5);
        #1;
        chk("t1_ram_en", 32'(ram_en), 32'd1);
        chk("t1_ram_wen", 32'(ram_wen), 32'd1);
        chk("t1_ram_addr", 32'(ram_addr), 32'h10);
        chk("t1_ram_din", 32'(ram_din), 32'hA5);
        tick();
        clear_acc();
        beat(0, 1'b0, 18'h00010, 8'h00);
        tick();
        clear_acc();
        chk("t1_rvalid", 32'(rvalid), 32'b001);
        chk("t1_rdata", 32'(rdata), 32'hA5);
        req = '0;
        tick();
        chk("t1_release_gnt", 32'(gnt), 32'd0);
        drive_acc(0, 1'b1, 18'h00022, 8'h77);
        #1;
        chk("t1_nogrant_ram_en", 32'(ram_en), 32'd0);
        chk("t1_nogrant_ram_addr", 32'(ram_addr), 32'd0);
        chk("t1_nogrant_ram_din", 32'(ram_din), 32'd0);
        tick();
        clear_acc();

        // 2: all request, 4-beat bursts, round-robin with one bubble
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            o = order[k];
            chk("t2_gnt_owner", 32'(gnt), 32'(1) << o);
            for (int b = 0; b < 4; b++) begin
                beat(o, 1'b1, ADDR_W'(32'h100 + 16*k + b), DATA_W'(k*16 + b + 1));
                if (b == 3) req[o] = 1'b0;
                tick();
                clear_acc();
                if (b < 3) chk("t2_gnt_hold", 32'(gnt), 32'(1) << o);
            end
            chk("t2_bubble", 32'(gnt), 32'd0);
            if (k < 3) req[o] = 1'b1;
            else       req = '0;
            tick();
        end
        chk("t2_idle_after", 32'(gnt), 32'd0);

        // 3: forced release at MAX_BURST=8 with requester 2 waiting
        req = 3'b010;
        tick();
        chk("t3_gnt1", 32'(gnt), 32'b010);
        for (int b = 1; b <= 8; b++) begin
            beat(1, 1'b0, ADDR_W'(32'h100 + b - 1), 8'h00);
            if (b == 3) req[2] = 1'b1;
            tick();
            clear_acc();
            if (b < 8) chk("t3_gnt_hold", 32'(gnt), 32'b010);
            else       chk("t3_forced_drop", 32'(gnt), 32'd0);
        end
        tick();
        chk("t3_gnt2", 32'(gnt), 32'b100);
        req[2] = 1'b0;
        tick();
        chk("t3_rel2", 32'(gnt), 32'd0);
        tick();
        chk("t3_regrant1", 32'(gnt), 32'b010);
        // nobody else waiting: burst limit passes without release
        for (int b = 0; b < 10; b++) begin
            beat(1, 1'b1, ADDR_W'(32'h200 + b), DATA_W'(8'h40 + b));
            tick();
            clear_acc();
            chk("t3_continue", 32'(gnt), 32'b010);
        end
        beat(1, 1'b1, 18'h3FFFF, 8'h5C);
        tick();
        clear_acc();
        chk("t3_continue_last", 32'(gnt), 32'b010);

        // 4: read at top address with simultaneous release
        beat(1, 1'b0, 18'h3FFFF, 8'h00);
        req[1] = 1'b0;
        req[0] = 1'b1;
        tick();
        clear_acc();
        chk("t4_gnt_drop", 32'(gnt), 32'd0);
        chk("t4_rvalid", 32'(rvalid), 32'b010);
        chk("t4_rdata", 32'(rdata), 32'h5C);
        tick();
        chk("t4_gnt0", 32'(gnt), 32'b001);
        chk("t4_no_rvalid", 32'(rvalid), 32'd0);

        // 5: non-owner access is ignored
        beat(0, 1'b1, 18'h00000, 8'h11);
        tick();
        clear_acc();
        drive_acc(2, 1'b1, 18'h00000, 8'hFF);
        #1;
        chk("t5_ram_en", 32'(ram_en), 32'd0);
        tick();
        clear_acc();
        beat(0, 1'b1, 18'h00005, 8'h33);
        drive_acc(2, 1'b1, 18'h00006, 8'hEE);
        #1;
        chk("t5_mux_addr", 32'(ram_addr), 32'h5);
        chk("t5_mux_din", 32'(ram_din), 32'h33);
        tick();
        clear_acc();
        beat(0, 1'b0, 18'h00000, 8'h00);
        tick();
        clear_acc();
        chk("t5_rvalid", 32'(rvalid), 32'b001);
        chk("t5_readback", 32'(rdata), 32'h11);

        // 6: reset mid-burst with a read in flight
        beat(0, 1'b1, 18'h00007, 8'h5A);
        tick();
        clear_acc();
        drive_acc(0, 1'b0, 18'h00007, 8'h00);
        rst_n = 1'b0;
        tick();
        clear_acc();
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_rvalid", 32'(rvalid), 32'd0);
        tick();
        chk("t6_rvalid_late", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        req   = 3'b111;
        tick();
        chk("t6_first_winner", 32'(gnt), 32'b001);
        req = '0;
        tick();
        chk("t6_release", 32'(gnt), 32'd0);
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
